// File: rtl/smart_order_sweep_router.sv
// Smart order router: snapshots venue top-of-book per parent order and sweeps it
// into child orders, best touch price first, until filled or no eligible venue remains.
module smart_order_sweep_router #(
    parameter int NUM_VENUES   = 4,
    parameter int SYM_W        = 64,
    parameter int PRICE_W      = 32,
    parameter int QTY_W        = 32,
    parameter int CNT_W        = 32,
    parameter int MAX_CHILDREN = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SYM_W-1:0]              in_symbol,
    input  logic [QTY_W-1:0]              in_qty,
    input  logic [PRICE_W-1:0]            in_price,
    input  logic [7:0]                    in_side,
    input  logic [NUM_VENUES*PRICE_W-1:0] venue_bid,
    input  logic [NUM_VENUES*PRICE_W-1:0] venue_ask,
    input  logic [NUM_VENUES*QTY_W-1:0]   venue_liq,
    input  logic [NUM_VENUES-1:0]         venue_enable,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_VENUES)-1:0] out_venue,
    output logic [SYM_W-1:0]              out_symbol,
    output logic [QTY_W-1:0]              out_qty,
    output logic [PRICE_W-1:0]            out_price,
    output logic [7:0]                    out_side,
    output logic                          out_last,
    output logic                          done_valid,
    output logic [QTY_W-1:0]              done_filled_qty,
    output logic [QTY_W-1:0]              done_residual_qty,
    output logic [NUM_VENUES*CNT_W-1:0]   venue_order_count,
    output logic [CNT_W-1:0]              unrouted_count
);

    localparam int VW  = $clog2(NUM_VENUES);
    localparam int NCW = $clog2(MAX_CHILDREN + 1);
    localparam logic [NUM_VENUES-1:0] ONE_V = NUM_VENUES'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t               state_r, state_nx_s;
    logic [SYM_W-1:0]     symbol_r;
    logic [7:0]           side_r;
    logic [QTY_W-1:0]     qty_r, rem_r, filled_r;
    logic [PRICE_W-1:0]   limit_r;
    logic [PRICE_W-1:0]   bid_r [NUM_VENUES];
    logic [PRICE_W-1:0]   ask_r [NUM_VENUES];
    logic [QTY_W-1:0]     liq_r [NUM_VENUES];
    logic [NUM_VENUES-1:0] en_r, used_r;
    logic [NCW-1:0]       nchild_r;
    logic [CNT_W-1:0]     cnt_r [NUM_VENUES];
    logic [CNT_W-1:0]     unrouted_r;

    logic                 in_ready_r, out_valid_r, out_last_r, done_valid_r;
    logic [VW-1:0]        out_venue_r;
    logic [QTY_W-1:0]     out_qty_r, done_filled_r, done_resid_r;
    logic [PRICE_W-1:0]   out_price_r;

    logic                 is_buy_s, found_s, others_s, last_s, accept_s;
    logic [PRICE_W-1:0]   touch_px_s [NUM_VENUES];
    logic [NUM_VENUES-1:0] elig_s;
    logic [VW-1:0]        best_s;
    logic [PRICE_W-1:0]   best_px_s;
    logic [QTY_W-1:0]     best_liq_s, child_qty_s;

    assign is_buy_s  = (side_r == 8'd1);
    assign accept_s  = (state_r == ST_EMIT) && out_ready;

    // Eligibility against the snapshot and best-venue search (price, then liquidity, then index).
    always_comb begin
        elig_s     = '0;
        found_s    = 1'b0;
        best_s     = '0;
        best_px_s  = '0;
        best_liq_s = '0;
        for (int i = 0; i < NUM_VENUES; i++) begin
            touch_px_s[i] = is_buy_s ? ask_r[i] : bid_r[i];
            if (en_r[i] && !used_r[i] && (liq_r[i] != '0) &&
                (is_buy_s ? (ask_r[i] <= limit_r) : (bid_r[i] >= limit_r))) begin
                elig_s[i] = 1'b1;
            end else begin
                elig_s[i] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_VENUES; i++) begin
            if (elig_s[i] && (!found_s ||
                (is_buy_s ? (touch_px_s[i] < best_px_s) : (touch_px_s[i] > best_px_s)) ||
                ((touch_px_s[i] == best_px_s) && (liq_r[i] > best_liq_s)))) begin
                found_s    = 1'b1;
                best_s     = VW'(i);
                best_px_s  = touch_px_s[i];
                best_liq_s = liq_r[i];
            end else begin
                found_s    = found_s;
            end
        end
    end

    assign child_qty_s = (rem_r < best_liq_s) ? rem_r : best_liq_s;
    assign others_s    = |(elig_s & ~(ONE_V << best_s));
    assign last_s      = (child_qty_s == rem_r) ||
                         ((nchild_r + NCW'(1)) == NCW'(MAX_CHILDREN)) || !others_s;

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) state_nx_s = ST_SELECT;
                else                        state_nx_s = ST_IDLE;
            end
            ST_SELECT: begin
                if ((qty_r == '0) || !found_s) state_nx_s = ST_FINISH;
                else                           state_nx_s = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) state_nx_s = out_last_r ? ST_FINISH : ST_SELECT;
                else           state_nx_s = ST_EMIT;
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= ST_IDLE;
        else       state_r <= state_nx_s;
    end

    // Parent snapshot, sweep bookkeeping, registered outputs and statistics.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            symbol_r      <= '0;
            side_r        <= 8'd0;
            qty_r         <= '0;
            rem_r         <= '0;
            filled_r      <= '0;
            limit_r       <= '0;
            en_r          <= '0;
            used_r        <= '0;
            nchild_r      <= '0;
            unrouted_r    <= '0;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_venue_r   <= '0;
            out_qty_r     <= '0;
            out_price_r   <= '0;
            done_valid_r  <= 1'b0;
            done_filled_r <= '0;
            done_resid_r  <= '0;
            for (int i = 0; i < NUM_VENUES; i++) begin
                bid_r[i] <= '0;
                ask_r[i] <= '0;
                liq_r[i] <= '0;
                cnt_r[i] <= '0;
            end
        end else begin
            in_ready_r   <= (state_nx_s == ST_IDLE);
            out_valid_r  <= (state_nx_s == ST_EMIT);
            done_valid_r <= (state_nx_s == ST_FINISH);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        symbol_r <= in_symbol;
                        side_r   <= in_side;
                        qty_r    <= in_qty;
                        limit_r  <= in_price;
                        rem_r    <= in_qty;
                        filled_r <= '0;
                        nchild_r <= '0;
                        used_r   <= '0;
                        en_r     <= venue_enable;
                        for (int i = 0; i < NUM_VENUES; i++) begin
                            bid_r[i] <= venue_bid[i*PRICE_W +: PRICE_W];
                            ask_r[i] <= venue_ask[i*PRICE_W +: PRICE_W];
                            liq_r[i] <= venue_liq[i*QTY_W +: QTY_W];
                        end
                    end
                end
                ST_SELECT: begin
                    if (state_nx_s == ST_EMIT) begin
                        used_r[best_s] <= 1'b1;
                        out_venue_r    <= best_s;
                        out_qty_r      <= child_qty_s;
                        out_price_r    <= best_px_s;
                        out_last_r     <= last_s;
                    end else begin
                        done_filled_r  <= filled_r;
                        done_resid_r   <= rem_r;
                    end
                end
                ST_EMIT: begin
                    if (accept_s) begin
                        rem_r              <= rem_r - out_qty_r;
                        filled_r           <= filled_r + out_qty_r;
                        nchild_r           <= nchild_r + NCW'(1);
                        cnt_r[out_venue_r] <= cnt_r[out_venue_r] + CNT_W'(1);
                        done_filled_r      <= filled_r + out_qty_r;
                        done_resid_r       <= rem_r - out_qty_r;
                    end
                end
                ST_FINISH: begin
                    if (rem_r != '0) unrouted_r <= unrouted_r + CNT_W'(1);
                end
                default: begin
                    used_r <= used_r;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VENUES; g++) begin : g_cnt
        assign venue_order_count[g*CNT_W +: CNT_W] = cnt_r[g];
    end

    assign in_ready          = in_ready_r;
    assign out_valid         = out_valid_r;
    assign out_venue         = out_venue_r;
    assign out_symbol        = symbol_r;
    assign out_qty           = out_qty_r;
    assign out_price         = out_price_r;
    assign out_side          = side_r;
    assign out_last          = out_last_r;
    assign done_valid        = done_valid_r;
    assign done_filled_qty   = done_filled_r;
    assign done_residual_qty = done_resid_r;
    assign unrouted_count    = unrouted_r;

endmodule
